// File: rtl/work_dispatch_pkg.sv
// Shared constants and types for the work dispatcher: frame layout, register
// addresses, the ID word and the golden-nonce FIFO entry.
package work_dispatch_pkg;

    localparam int unsigned FRAME_W       = 38;
    localparam int unsigned FRAME_PAR     = 37;
    localparam int unsigned FRAME_WE      = 36;
    localparam int unsigned FRAME_ADDR_HI = 35;
    localparam int unsigned FRAME_ADDR_LO = 32;
    localparam int unsigned GN_NONCE_W    = 60;
    localparam int unsigned CORE_IDX_W    = 4;

    localparam logic [3:0] ADDR_ID       = 4'h0;
    localparam logic [3:0] ADDR_HASH0    = 4'h1;
    localparam logic [3:0] ADDR_HASH1    = 4'h2;
    localparam logic [3:0] ADDR_HASH2    = 4'h3;
    localparam logic [3:0] ADDR_HASH3    = 4'h4;
    localparam logic [3:0] ADDR_HASH4    = 4'h5;
    localparam logic [3:0] ADDR_FIXED0   = 4'h6;
    localparam logic [3:0] ADDR_FIXED1   = 4'h7;
    localparam logic [3:0] ADDR_NONCE_LO = 4'h8;
    localparam logic [3:0] ADDR_NONCE_HI = 4'h9;
    localparam logic [3:0] ADDR_STATUS   = 4'hA;
    localparam logic [3:0] ADDR_GN_LO    = 4'hD;
    localparam logic [3:0] ADDR_GN_HI    = 4'hE;

    typedef struct packed {
        logic [CORE_IDX_W-1:0] core_idx;
        logic [GN_NONCE_W-1:0] nonce;
    } gn_entry_t;

    function automatic logic [31:0] id_word(input int unsigned num_cores);
        return {8'h02, 8'(num_cores), 16'h0100};
    endfunction

endpackage

// File: rtl/gn_fifo.sv
// Synchronous FIFO of golden-nonce entries; pushes when full and pops when
// empty are ignored.
module gn_fifo
    import work_dispatch_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  gn_entry_t        push_data,
    input  logic             pop,
    output gn_entry_t        head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int unsigned PTR_W = CNT_W - 1;

    gn_entry_t        mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem_q[rd_ptr_q];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/work_dispatch.sv
// Host register bank, atomic job commit with per-core nonce partitions, and
// golden-nonce collection through per-core holders and a round-robin arbiter.
module work_dispatch
    import work_dispatch_pkg::*;
#(
    parameter int unsigned NUM_CORES   = 4,
    parameter int unsigned NONCE_WIDTH = 60,
    parameter int unsigned FIXED_WIDTH = 56,
    parameter int unsigned HASH_WIDTH  = 160,
    parameter int unsigned PART_SHIFT  = 52,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                             rx_hash_clk,
    input  logic                             rx_reset_n,
    input  logic                             req_valid,
    input  logic [FRAME_W-1:0]               req_frame,
    output logic                             rsp_valid,
    output logic                             rsp_err,
    output logic [31:0]                      rsp_data,
    input  logic [NUM_CORES-1:0]             gn_valid,
    input  logic [NUM_CORES*NONCE_WIDTH-1:0] gn_nonce,
    output logic                             tx_new_work,
    output logic [FIXED_WIDTH-1:0]           tx_fixed_data,
    output logic [HASH_WIDTH-1:0]            tx_target_hash,
    output logic [NUM_CORES*NONCE_WIDTH-1:0] tx_start_nonce
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic        frame_ok, wr_en, rd_en;
    logic [3:0]  req_addr;
    logic [31:0] req_data, rd_data;

    assign frame_ok = ~^req_frame;
    assign req_addr = req_frame[FRAME_ADDR_HI:FRAME_ADDR_LO];
    assign req_data = req_frame[31:0];
    assign wr_en    = req_valid && frame_ok && req_frame[FRAME_WE];
    assign rd_en    = req_valid && frame_ok && !req_frame[FRAME_WE];

    logic [31:0] hash_stage_q [5];
    logic [31:0] fixed_stage_q [2];
    logic [31:0] nonce_lo_q, nonce_hi_q;
    logic [31:0] gn_latch_q;
    logic        overflow_q, overflow_d;

    logic [NONCE_WIDTH-1:0]           hold_nonce_q [NUM_CORES];
    logic [NONCE_WIDTH-1:0]           hold_nonce_d [NUM_CORES];
    logic [NUM_CORES-1:0]             hold_full_q, hold_full_d;
    logic [CORE_IDX_W-1:0]            rr_ptr_q, rr_ptr_d;
    logic [NUM_CORES-1:0]             grant;
    logic                             grant_any;
    logic [CORE_IDX_W-1:0]            grant_idx;
    logic [NONCE_WIDTH-1:0]           grant_nonce;
    logic [4:0]                       busy_cnt;
    logic [NONCE_WIDTH-1:0]           start_base;
    logic [NUM_CORES*NONCE_WIDTH-1:0] start_next;

    gn_entry_t        push_entry, fifo_head;
    logic             fifo_full, fifo_empty, fifo_pop;
    logic [CNT_W-1:0] fifo_count;

    gn_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .CNT_W      (CNT_W)
    ) u_gn_fifo (
        .clk       (rx_hash_clk),
        .reset_n   (rx_reset_n),
        .push      (grant_any),
        .push_data (push_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign fifo_pop = rd_en && (req_addr == ADDR_GN_LO) && !fifo_empty;

    // Commit takes the high word straight from the frame so the job is atomic.
    assign start_base = NONCE_WIDTH'({req_data, nonce_lo_q});

    always_comb begin
        start_next = '0;
        for (int i = 0; i < int'(NUM_CORES); i++) begin
            start_next[i*NONCE_WIDTH +: NONCE_WIDTH] =
                start_base + (NONCE_WIDTH'(i) << PART_SHIFT);
        end
    end

    // Round-robin: lowest full holder at or above the pointer, else lowest below it.
    always_comb begin
        logic                  found_hi, found_lo;
        logic [CORE_IDX_W-1:0] idx_hi, idx_lo;
        found_hi = 1'b0;
        found_lo = 1'b0;
        idx_hi   = '0;
        idx_lo   = '0;
        for (int j = int'(NUM_CORES) - 1; j >= 0; j--) begin
            if (hold_full_q[j]) begin
                if (CORE_IDX_W'(j) >= rr_ptr_q) begin
                    found_hi = 1'b1;
                    idx_hi   = CORE_IDX_W'(j);
                end else begin
                    found_lo = 1'b1;
                    idx_lo   = CORE_IDX_W'(j);
                end
            end
        end
        grant_any = !fifo_full && (found_hi || found_lo);
        grant_idx = found_hi ? idx_hi : idx_lo;
        grant     = grant_any ? (NUM_CORES'(1) << grant_idx) : '0;
        rr_ptr_d  = rr_ptr_q;
        if (grant_any) begin
            rr_ptr_d = (grant_idx == CORE_IDX_W'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_comb begin
        grant_nonce = '0;
        busy_cnt    = '0;
        for (int j = 0; j < int'(NUM_CORES); j++) begin
            if (grant[j]) grant_nonce = hold_nonce_q[j];
            busy_cnt = busy_cnt + 5'(hold_full_q[j]);
        end
        push_entry.core_idx = grant_idx;
        push_entry.nonce    = GN_NONCE_W'(grant_nonce);
    end

    // A holder being drained this cycle can accept a new strobe without loss.
    always_comb begin
        overflow_d = overflow_q;
        if (wr_en && (req_addr == ADDR_STATUS)) overflow_d = 1'b0;
        for (int j = 0; j < int'(NUM_CORES); j++) begin
            hold_full_d[j]  = hold_full_q[j];
            hold_nonce_d[j] = hold_nonce_q[j];
            if (gn_valid[j]) begin
                if (!hold_full_q[j] || grant[j]) begin
                    hold_full_d[j]  = 1'b1;
                    hold_nonce_d[j] = gn_nonce[j*NONCE_WIDTH +: NONCE_WIDTH];
                end else begin
                    overflow_d = 1'b1;
                end
            end else if (grant[j]) begin
                hold_full_d[j] = 1'b0;
            end
        end
    end

    always_comb begin
        rd_data = 32'hFFFF_FFFF;
        case (req_addr)
            ADDR_ID:       rd_data = id_word(NUM_CORES);
            ADDR_HASH0:    rd_data = hash_stage_q[0];
            ADDR_HASH1:    rd_data = hash_stage_q[1];
            ADDR_HASH2:    rd_data = hash_stage_q[2];
            ADDR_HASH3:    rd_data = hash_stage_q[3];
            ADDR_HASH4:    rd_data = hash_stage_q[4];
            ADDR_FIXED0:   rd_data = fixed_stage_q[0];
            ADDR_FIXED1:   rd_data = fixed_stage_q[1];
            ADDR_NONCE_LO: rd_data = nonce_lo_q;
            ADDR_NONCE_HI: rd_data = nonce_hi_q;
            ADDR_STATUS:   rd_data = {overflow_q, 15'd0, 8'(busy_cnt), 8'(fifo_count)};
            ADDR_GN_LO:    rd_data = fifo_empty ? 32'hFFFF_FFFF : fifo_head.nonce[31:0];
            ADDR_GN_HI:    rd_data = gn_latch_q;
            default:       rd_data = 32'hFFFF_FFFF;
        endcase
    end

    always_ff @(posedge rx_hash_clk) begin
        if (!rx_reset_n) begin
            rsp_valid      <= 1'b0;
            rsp_err        <= 1'b0;
            rsp_data       <= '0;
            tx_new_work    <= 1'b0;
            tx_fixed_data  <= '0;
            tx_target_hash <= '0;
            tx_start_nonce <= '0;
            nonce_lo_q     <= '0;
            nonce_hi_q     <= '0;
            gn_latch_q     <= '0;
            overflow_q     <= 1'b0;
            rr_ptr_q       <= '0;
            hold_full_q    <= '0;
            for (int i = 0; i < 5; i++) hash_stage_q[i] <= '0;
            for (int i = 0; i < 2; i++) fixed_stage_q[i] <= '0;
            for (int j = 0; j < int'(NUM_CORES); j++) hold_nonce_q[j] <= '0;
        end else begin
            rsp_valid   <= req_valid;
            rsp_err     <= req_valid && !frame_ok;
            rsp_data    <= rd_en ? rd_data : 32'd0;
            tx_new_work <= wr_en && (req_addr == ADDR_NONCE_HI);
            overflow_q  <= overflow_d;
            rr_ptr_q    <= rr_ptr_d;
            hold_full_q <= hold_full_d;
            for (int j = 0; j < int'(NUM_CORES); j++) hold_nonce_q[j] <= hold_nonce_d[j];
            if (fifo_pop) gn_latch_q <= {fifo_head.core_idx, fifo_head.nonce[59:32]};
            if (wr_en) begin
                case (req_addr)
                    ADDR_HASH0:    hash_stage_q[0]  <= req_data;
                    ADDR_HASH1:    hash_stage_q[1]  <= req_data;
                    ADDR_HASH2:    hash_stage_q[2]  <= req_data;
                    ADDR_HASH3:    hash_stage_q[3]  <= req_data;
                    ADDR_HASH4:    hash_stage_q[4]  <= req_data;
                    ADDR_FIXED0:   fixed_stage_q[0] <= req_data;
                    ADDR_FIXED1:   fixed_stage_q[1] <= req_data;
                    ADDR_NONCE_LO: nonce_lo_q       <= req_data;
                    ADDR_NONCE_HI: begin
                        nonce_hi_q     <= req_data;
                        tx_start_nonce <= start_next;
                        tx_fixed_data  <= FIXED_WIDTH'({fixed_stage_q[1], fixed_stage_q[0]});
                        tx_target_hash <= HASH_WIDTH'({hash_stage_q[4], hash_stage_q[3],
                                                       hash_stage_q[2], hash_stage_q[1],
                                                       hash_stage_q[0]});
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_work_dispatch.sv
// Directed self-checking bench for work_dispatch with default parameters.
module tb_work_dispatch;

    localparam int NC = 4;
    localparam int NW = 60;

    logic              rx_hash_clk = 1'b0;
    logic              rx_reset_n  = 1'b0;
    logic              req_valid   = 1'b0;
    logic [37:0]       req_frame   = '0;
    logic              rsp_valid, rsp_err;
    logic [31:0]       rsp_data;
    logic [NC-1:0]     gn_valid    = '0;
    logic [NC*NW-1:0]  gn_nonce    = '0;
    logic              tx_new_work;
    logic [55:0]       tx_fixed_data;
    logic [159:0]      tx_target_hash;
    logic [NC*NW-1:0]  tx_start_nonce;

    int checks   = 0;
    int failures = 0;

    always #5 rx_hash_clk = ~rx_hash_clk;

    work_dispatch dut (
        .rx_hash_clk    (rx_hash_clk),
        .rx_reset_n     (rx_reset_n),
        .req_valid      (req_valid),
        .req_frame      (req_frame),
        .rsp_valid      (rsp_valid),
        .rsp_err        (rsp_err),
        .rsp_data       (rsp_data),
        .gn_valid       (gn_valid),
        .gn_nonce       (gn_nonce),
        .tx_new_work    (tx_new_work),
        .tx_fixed_data  (tx_fixed_data),
        .tx_target_hash (tx_target_hash),
        .tx_start_nonce (tx_start_nonce)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [37:0] mk(input logic we, input logic [3:0] a, input logic [31:0] d);
        logic [36:0] body;
        body = {we, a, d};
        return {^body, body};
    endfunction

    task automatic xfer(input logic [37:0] f, output logic [33:0] r);
        @(negedge rx_hash_clk);
        req_valid = 1'b1;
        req_frame = f;
        @(negedge rx_hash_clk);
        req_valid = 1'b0;
        req_frame = '0;
        r = {rsp_valid, rsp_err, rsp_data};
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [31:0] exp);
        logic [33:0] r;
        xfer(mk(1'b0, a, 32'd0), r);
        check(tag, 64'(r), 64'({2'b10, exp}));
    endtask

    task automatic rd_nochk(input logic [3:0] a);
        logic [33:0] r;
        xfer(mk(1'b0, a, 32'd0), r);
    endtask

    task automatic wr(input string tag, input logic [3:0] a, input logic [31:0] d);
        logic [33:0] r;
        xfer(mk(1'b1, a, d), r);
        check(tag, 64'(r), 64'({2'b10, 32'd0}));
    endtask

    task automatic pulse(input logic [NC-1:0] mask, input logic [NC*NW-1:0] n);
        @(negedge rx_hash_clk);
        gn_valid = mask;
        gn_nonce = n;
        @(negedge rx_hash_clk);
        gn_valid = '0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge rx_hash_clk);
    endtask

    logic [NW-1:0]    n0, n1, n2, n3, p0, p1;
    logic [NC*NW-1:0] nv;
    logic [37:0]      f;
    logic [33:0]      r;

    initial begin
        n0 = 60'h111_1111_0000_0010;
        n1 = 60'h222_2222_0000_0011;
        n2 = 60'h333_3333_0000_0012;
        n3 = 60'h444_4444_0000_0013;
        p0 = 60'hABC_DEF0_0000_0100;
        p1 = 60'h123_4567_0000_0101;
        nv = {n3, n2, n1, n0};

        idle(3);
        check("reset_outputs", 64'({rsp_valid, rsp_err, tx_new_work, |rsp_data,
                                    |tx_start_nonce, |tx_target_hash, |tx_fixed_data}), 64'd0);
        rx_reset_n = 1'b1;
        idle(1);
        rd("reset_status", 4'hA, 32'h0000_0000);

        // ID and parity
        rd("id_read", 4'h0, 32'h0204_0100);
        f = mk(1'b0, 4'h0, 32'd0);
        f[37] = ~f[37];
        xfer(f, r);
        check("bad_parity_read", 64'(r), 64'({2'b11, 32'd0}));
        f = mk(1'b1, 4'h9, 32'h0000_1234);
        f[37] = ~f[37];
        xfer(f, r);
        check("bad_parity_commit", 64'({r[33:32], tx_new_work, |tx_start_nonce}), 64'(4'b1100));
        rd("unmapped_read", 4'hB, 32'hFFFF_FFFF);

        // Job staging and commit
        wr("wr_hash0", 4'h1, 32'h1111_1111);
        wr("wr_hash1", 4'h2, 32'h2222_2222);
        wr("wr_hash2", 4'h3, 32'h3333_3333);
        wr("wr_hash3", 4'h4, 32'h4444_4444);
        wr("wr_hash4", 4'h5, 32'h5555_5555);
        wr("wr_fixed0", 4'h6, 32'h6666_6666);
        wr("wr_fixed1", 4'h7, 32'h7777_7777);
        wr("wr_nonce_lo", 4'h8, 32'h0000_0005);
        check("staging_no_tx", 64'({tx_new_work, |tx_target_hash, |tx_fixed_data,
                                    |tx_start_nonce}), 64'd0);
        wr("wr_commit", 4'h9, 32'h0FFF_FFFF);
        check("new_work_pulse", 64'(tx_new_work), 64'd1);
        idle(1);
        check("new_work_single", 64'(tx_new_work), 64'd0);
        check("core0_start", 64'(tx_start_nonce[0*NW +: NW]), 64'h0FFF_FFFF_0000_0005);
        check("core1_start", 64'(tx_start_nonce[1*NW +: NW]), 64'h000F_FFFF_0000_0005);
        check("core3_start", 64'(tx_start_nonce[3*NW +: NW]), 64'h002F_FFFF_0000_0005);
        check("hash_w0", 64'(tx_target_hash[31:0]), 64'h1111_1111);
        check("hash_w2", 64'(tx_target_hash[95:64]), 64'h3333_3333);
        check("hash_w4", 64'(tx_target_hash[159:128]), 64'h5555_5555);
        check("fixed_data", 64'(tx_fixed_data), 64'h0077_7777_6666_6666);

        // All cores strobe together: entries land in core order
        pulse(4'hF, nv);
        idle(5);
        rd("status_4", 4'hA, 32'h0000_0004);
        rd("pop_c0_lo", 4'hD, 32'h0000_0010);
        rd("pop_c0_hi", 4'hE, 32'h0111_1111);
        rd("pop_c1_lo", 4'hD, 32'h0000_0011);
        rd("pop_c1_hi", 4'hE, 32'h1222_2222);
        rd("pop_c2_lo", 4'hD, 32'h0000_0012);
        rd("pop_c2_hi", 4'hE, 32'h2333_3333);
        rd("pop_c3_lo", 4'hD, 32'h0000_0013);
        rd("pop_c3_hi", 4'hE, 32'h3444_4444);
        rd("status_empty", 4'hA, 32'h0000_0000);

        // FIFO full: holders wait, overflow only on a strobe into a stuck holder
        pulse(4'hF, nv);
        idle(5);
        pulse(4'hF, nv);
        idle(5);
        rd("status_full", 4'hA, 32'h0000_0008);
        pulse(4'b0011, {{(2*NW){1'b0}}, p1, p0});
        idle(2);
        rd("status_held", 4'hA, 32'h0000_0208);
        rd("pop_when_full", 4'hD, 32'h0000_0010);
        rd("status_refill", 4'hA, 32'h0000_0108);
        pulse(4'b0010, {{(2*NW){1'b0}}, 60'hFFF_FFFF_FFFF_FFFF, {NW{1'b0}}});
        rd("status_overflow", 4'hA, 32'h8000_0108);
        wr("clear_overflow", 4'hA, 32'h0000_0000);
        rd("status_cleared", 4'hA, 32'h0000_0108);
        repeat (7) rd_nochk(4'hD);
        rd("pop_p0_lo", 4'hD, 32'h0000_0100);
        rd("pop_p0_hi", 4'hE, 32'h0ABC_DEF0);
        rd("pop_p1_lo", 4'hD, 32'h0000_0101);
        rd("pop_p1_hi", 4'hE, 32'h1123_4567);

        // Empty pop leaves count and latch untouched
        rd("empty_pop", 4'hD, 32'hFFFF_FFFF);
        rd("empty_status", 4'hA, 32'h0000_0000);
        rd("latch_kept", 4'hE, 32'h1123_4567);

        // Push and pop in the same cycle
        pulse(4'b0100, nv);
        idle(2);
        rd("status_one", 4'hA, 32'h0000_0001);
        @(negedge rx_hash_clk);
        gn_valid = 4'b1000;
        gn_nonce = nv;
        @(negedge rx_hash_clk);
        gn_valid  = '0;
        req_valid = 1'b1;
        req_frame = mk(1'b0, 4'hD, 32'd0);
        @(negedge rx_hash_clk);
        req_valid = 1'b0;
        req_frame = '0;
        check("pushpop_data", 64'(rsp_data), 64'h0000_0012);
        rd("pushpop_count", 4'hA, 32'h0000_0001);
        rd("pushpop_c3", 4'hD, 32'h0000_0013);

        // Reset with work in flight
        pulse(4'hF, nv);
        idle(5);
        pulse(4'hF, nv);
        idle(5);
        pulse(4'b0001, nv);
        pulse(4'b0001, nv);
        rd("pre_reset_status", 4'hA, 32'h8000_0108);
        @(negedge rx_hash_clk);
        rx_reset_n = 1'b0;
        idle(2);
        check("reset_mid_outputs", 64'({rsp_valid, rsp_err, tx_new_work, |rsp_data,
                                        |tx_start_nonce, |tx_target_hash, |tx_fixed_data}), 64'd0);
        rx_reset_n = 1'b1;
        idle(3);
        rd("reset_mid_status", 4'hA, 32'h0000_0000);
        rd("reset_mid_latch", 4'hE, 32'h0000_0000);
        rd("reset_mid_pop", 4'hD, 32'hFFFF_FFFF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
